debounce_edge: RTL and testbench

- Input conditioning stage that sits directly upstream of the lab flip-flop and counter blocks. It feeds their d/clock-enable inputs from mechanical push-buttons and switches.
- Synchronises a raw asynchronous input into the clk domain with two flops.
- Filters contact bounce with a stability counter and FSM.
- Outputs a clean level plus single-cycle rise and fall pulses.

---
 rtl/dbnc_pkg.sv | 31 +++
 rtl/debounce_edge_if.sv | 31 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/debounce_edge.sv | 137 +++++++++++++
 tb/tb_debounce_edge.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/dbnc_pkg.sv
// ---------------------------------------------------------------------------
// dbnc_pkg
// Shared definitions for the push-button/switch debouncer:
//   state_e             - FSM state encoding (two IDLE and two WAIT states)
//   STABLE_CNT_DEFAULT  - stability window for a real board clock
//   CNT_W_DEFAULT       - default stability counter width
//   STABLE_CNT_SIM      - short stability window used in simulation
//   stable_cnt_legal()  - parameter range helper for elaboration checks
// ---------------------------------------------------------------------------
package dbnc_pkg;

  // Encoding keeps bit 1 equal to the debounced level while idle, so the two
  // IDLE states differ from their WAIT neighbours in a single bit.
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b11,
    WAIT_LO = 2'b10
  } state_e;

  localparam int STABLE_CNT_DEFAULT = 50000;
  localparam int CNT_W_DEFAULT      = 16;
  localparam int STABLE_CNT_SIM     = 4;

  // The counter tops out at stable_cnt-1, so stable_cnt itself must still
  // fit in cnt_w bits and at least one cycle of stability is required.
  function automatic bit stable_cnt_legal(input int stable_cnt, input int cnt_w);
    return (stable_cnt >= 1) && (longint'(stable_cnt) < (longint'(1) << cnt_w));
  endfunction

endpackage

// File: rtl/debounce_edge_if.sv
// ---------------------------------------------------------------------------
// debounce_edge_if
// Signal bundle between a button source and the debouncer.
//   btn_in     - raw asynchronous button/switch level
//   level_out  - debounced level
//   rise_pulse - one-cycle pulse on a debounced 0->1 change
//   fall_pulse - one-cycle pulse on a debounced 1->0 change
// Modports:
//   master - button side (drives btn_in, observes the conditioned outputs)
//   slave  - debouncer side
// ---------------------------------------------------------------------------
interface debounce_edge_if;
  logic btn_in;
  logic level_out;
  logic rise_pulse;
  logic fall_pulse;

  modport master (
    output btn_in,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  btn_in,
    output level_out,
    output rise_pulse,
    output fall_pulse
  );
endinterface

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
// Both flops clear to 0 while rst is low.
//   clk  - destination clock
//   rst  - asynchronous active-low reset
//   i_d  - asynchronous input level
//   o_q  - synchronised level (second flop)
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/debounce_edge.sv
// ---------------------------------------------------------------------------
// debounce_edge
// Conditions a mechanical button/switch: synchronises it, rejects bounce
// shorter than STABLE_CNT cycles, and produces a clean level plus registered
// single-cycle rise/fall pulses.
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - debounce_edge_if.slave: btn_in in; level_out, rise_pulse,
//          fall_pulse out (all outputs come straight from flops)
// Parameters:
//   STABLE_CNT - cycles the synchronised input must disagree with level_out
//                before level_out follows it (1 .. 2**CNT_W-1)
//   CNT_W      - stability counter width
// ---------------------------------------------------------------------------
module debounce_edge
  import dbnc_pkg::*;
#(
  parameter int STABLE_CNT = STABLE_CNT_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  debounce_edge_if.slave bus
);

  if (!stable_cnt_legal(STABLE_CNT, CNT_W)) begin : g_param_check
    $error("debounce_edge: STABLE_CNT=%0d must lie in 1 .. 2**CNT_W-1 (CNT_W=%0d)",
           STABLE_CNT, CNT_W);
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic             w_s2;
  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_level;
  logic             w_level_next;
  logic             r_rise;
  logic             w_rise_next;
  logic             r_fall;
  logic             w_fall_next;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.btn_in),
    .o_q (w_s2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_level <= w_level_next;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
    end
  end

  // The first disagreeing sample already counts as cycle 1, so the commit
  // happens when the counter holds STABLE_CNT-1 and one more sample agrees.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_level_next = r_level;
    w_rise_next  = 1'b0;
    w_fall_next  = 1'b0;
    unique case (r_state)
      IDLE_LO: begin
        if (w_s2) begin
          if (STABLE_CNT == 1) begin
            w_state_next = IDLE_HI;
            w_level_next = 1'b1;
            w_rise_next  = 1'b1;
            w_cnt_next   = '0;
          end else begin
            w_state_next = WAIT_HI;
            w_cnt_next   = ONE_CNT;
          end
        end
      end
      WAIT_HI: begin
        if (!w_s2) begin
          w_state_next = IDLE_LO;
          w_cnt_next   = '0;
        end else if (r_cnt == LAST_CNT) begin
          w_state_next = IDLE_HI;
          w_level_next = 1'b1;
          w_rise_next  = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + ONE_CNT;
        end
      end
      IDLE_HI: begin
        if (!w_s2) begin
          if (STABLE_CNT == 1) begin
            w_state_next = IDLE_LO;
            w_level_next = 1'b0;
            w_fall_next  = 1'b1;
            w_cnt_next   = '0;
          end else begin
            w_state_next = WAIT_LO;
            w_cnt_next   = ONE_CNT;
          end
        end
      end
      WAIT_LO: begin
        if (w_s2) begin
          w_state_next = IDLE_HI;
          w_cnt_next   = '0;
        end else if (r_cnt == LAST_CNT) begin
          w_state_next = IDLE_LO;
          w_level_next = 1'b0;
          w_fall_next  = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + ONE_CNT;
        end
      end
    endcase
  end

  assign bus.level_out  = r_level;
  assign bus.rise_pulse = r_rise;
  assign bus.fall_pulse = r_fall;

endmodule

// File: tb/tb_debounce_edge.sv
// ---------------------------------------------------------------------------
// tb_debounce_edge
// Directed bench for debounce_edge. dut_a uses the short simulation window
// (STABLE_CNT=4); dut_b uses the minimum window (STABLE_CNT=1). Each step
// drives btn_in on the falling edge, queues the expected outputs
// {level_out, rise_pulse, fall_pulse} for both DUTs, and compares them 1 ns
// after the following rising edge. Edge 0 is the first rising edge that
// samples a new btn_in value.
// ---------------------------------------------------------------------------
module tb_debounce_edge;
  import dbnc_pkg::*;

  localparam logic [2:0] Z    = 3'b000;  // level 0, no pulse
  localparam logic [2:0] HI   = 3'b100;  // level 1, no pulse
  localparam logic [2:0] RISE = 3'b110;  // level 1, rise pulse
  localparam logic [2:0] FALL = 3'b001;  // level 0, fall pulse

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  debounce_edge_if bus_a ();
  debounce_edge_if bus_b ();

  debounce_edge #(.STABLE_CNT(STABLE_CNT_SIM), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  debounce_edge #(.STABLE_CNT(1), .CNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    string      tag;
    logic [2:0] exp_a;
    logic [2:0] exp_b;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] ea, input logic [2:0] eb);
    check_val({tag, ":a.level"}, 16'(bus_a.level_out),  16'(ea[2]));
    check_val({tag, ":a.rise"},  16'(bus_a.rise_pulse), 16'(ea[1]));
    check_val({tag, ":a.fall"},  16'(bus_a.fall_pulse), 16'(ea[0]));
    check_val({tag, ":b.level"}, 16'(bus_b.level_out),  16'(eb[2]));
    check_val({tag, ":b.rise"},  16'(bus_b.rise_pulse), 16'(eb[1]));
    check_val({tag, ":b.fall"},  16'(bus_b.fall_pulse), 16'(eb[0]));
  endtask

  // Entered just after a falling edge; returns at the next falling edge.
  task automatic cyc(input string tag, input logic ba, input logic bb,
                     input logic [2:0] ea, input logic [2:0] eb);
    exp_t e;
    exp_t got;
    bus_a.btn_in = ba;
    bus_b.btn_in = bb;
    e.tag   = tag;
    e.exp_a = ea;
    e.exp_b = eb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check_outputs(got.tag, got.exp_a, got.exp_b);
    $display("[%0t] %s rst=%b | a: btn=%b lvl=%b rise=%b fall=%b | b: btn=%b lvl=%b rise=%b fall=%b",
             $time, got.tag, rst, ba, bus_a.level_out, bus_a.rise_pulse, bus_a.fall_pulse,
             bb, bus_b.level_out, bus_b.rise_pulse, bus_b.fall_pulse);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst          = 1'b0;
    bus_a.btn_in = 1'b0;
    bus_b.btn_in = 1'b0;
    @(negedge clk);

    // Reset held across clock edges
    cyc("reset0", 1'b0, 1'b0, Z, Z);
    cyc("reset1", 1'b0, 1'b0, Z, Z);
    check_val("reset_cnt", dut_a.r_cnt, 16'd0);
    rst = 1'b1;
    cyc("idle0", 1'b0, 1'b0, Z, Z);
    cyc("idle1", 1'b0, 1'b0, Z, Z);

    // Bounce: high 2, low 1, high 3, then low -> no change at STABLE_CNT=4
    cyc("bounce_e0", 1'b1, 1'b0, Z, Z);
    cyc("bounce_e1", 1'b1, 1'b0, Z, Z);
    cyc("bounce_e2", 1'b0, 1'b0, Z, Z);
    cyc("bounce_e3", 1'b1, 1'b0, Z, Z);
    cyc("bounce_e4", 1'b1, 1'b0, Z, Z);
    cyc("bounce_e5", 1'b1, 1'b0, Z, Z);
    for (int i = 6; i < 11; i++) cyc($sformatf("bounce_e%0d", i), 1'b0, 1'b0, Z, Z);
    check_val("bounce_cnt", dut_a.r_cnt, 16'd0);

    // Clean press: rise at edge 5, gone at edge 6
    for (int i = 0; i < 5; i++) cyc($sformatf("press_e%0d", i), 1'b1, 1'b0, Z, Z);
    cyc("press_e5", 1'b1, 1'b0, RISE, Z);
    cyc("press_e6", 1'b1, 1'b0, HI, Z);
    cyc("press_e7", 1'b1, 1'b0, HI, Z);
    check_val("press_cnt", dut_a.r_cnt, 16'd0);

    // Clean release: fall at edge 5 for one cycle
    for (int i = 0; i < 5; i++) cyc($sformatf("release_e%0d", i), 1'b0, 1'b0, HI, Z);
    cyc("release_e5", 1'b0, 1'b0, FALL, Z);
    cyc("release_e6", 1'b0, 1'b0, Z, Z);
    cyc("release_e7", 1'b0, 1'b0, Z, Z);

    // Reset in the middle of WAIT_HI, released with btn_in still high
    for (int i = 0; i < 4; i++) cyc($sformatf("rstwait_e%0d", i), 1'b1, 1'b0, Z, Z);
    rst = 1'b0;
    #1;
    check_outputs("rstwait_async", Z, Z);
    check_val("rstwait_cnt", dut_a.r_cnt, 16'd0);
    cyc("rstwait_hold0", 1'b1, 1'b0, Z, Z);
    cyc("rstwait_hold1", 1'b1, 1'b0, Z, Z);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) cyc($sformatf("rstwait_post_e%0d", i), 1'b1, 1'b0, Z, Z);
    cyc("rstwait_post_e5", 1'b1, 1'b0, RISE, Z);
    cyc("rstwait_post_e6", 1'b1, 1'b0, HI, Z);

    // Mid-cycle reset while level_out=1 and btn_in=1: clears with no edge
    rst = 1'b0;
    #1;
    check_outputs("async_rst", Z, Z);
    cyc("async_rst_hold", 1'b0, 1'b0, Z, Z);
    rst = 1'b1;
    cyc("async_rst_idle0", 1'b0, 1'b0, Z, Z);
    cyc("async_rst_idle1", 1'b0, 1'b0, Z, Z);

    // STABLE_CNT=1: one-cycle btn pulse -> rise at edge 2, fall at edge 3
    cyc("min_e0", 1'b0, 1'b1, Z, Z);
    cyc("min_e1", 1'b0, 1'b0, Z, Z);
    cyc("min_e2", 1'b0, 1'b0, Z, RISE);
    cyc("min_e3", 1'b0, 1'b0, Z, FALL);
    cyc("min_e4", 1'b0, 1'b0, Z, Z);
    cyc("min_e5", 1'b0, 1'b0, Z, Z);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
